neuron_layer3_integrator: RTL and testbench

NEURON_LAYER3_INTEGRATOR -- requirements
Module: neuron_layer3_integrator

---
 rtl/neuron_layer3_integrator.sv | 135 +++++++++++++
 tb/tb_neuron_layer3_integrator.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/neuron_layer3_integrator.sv
// Per-timestep integrator for one layer-3 neuron: accumulates weighted spikes
// onto the membrane, applies a shift-based leak, then fires or writes the result back.
module neuron_layer3_integrator #(
  parameter int BIT_WIDTH_MEMBRANE     = 16,
  parameter int BIT_WIDTH_BIG_MEMBRANE = 16,
  parameter int BIT_WIDTH_WEIGHT       = 8,
  parameter int LEAK_SHIFT             = 3
) (
  input  logic                                     clk,
  input  logic                                     reset_n,
  input  logic                                     ts_start_i,
  input  logic                                     spike_valid_i,
  input  logic signed [BIT_WIDTH_WEIGHT-1:0]       spike_weight_i,
  input  logic                                     ts_end_i,
  input  logic signed [BIT_WIDTH_MEMBRANE-1:0]     threshold_i,
  input  logic signed [BIT_WIDTH_MEMBRANE-1:0]     membrane_i,
  input  logic signed [BIT_WIDTH_BIG_MEMBRANE-1:0] big_membrane_i,
  output logic signed [BIT_WIDTH_MEMBRANE-1:0]     membrane_update_o,
  output logic                                     membrane_update_valid_o,
  output logic signed [BIT_WIDTH_BIG_MEMBRANE-1:0] big_membrane_update_o,
  output logic                                     big_membrane_update_valid_o,
  output logic                                     post_spiking_now_o,
  output logic                                     busy_o,
  output logic                                     done_o,
  output logic [7:0]                               spike_cnt_o,
  output logic                                     err_o
);

  localparam int M = BIT_WIDTH_MEMBRANE;
  localparam int B = BIT_WIDTH_BIG_MEMBRANE;
  localparam int W = BIT_WIDTH_WEIGHT;

  localparam logic signed [M-1:0] MEM_MAX = {1'b0, {(M-1){1'b1}}};
  localparam logic signed [M-1:0] MEM_MIN = {1'b1, {(M-1){1'b0}}};
  localparam logic signed [B-1:0] BIG_MAX = {1'b0, {(B-1){1'b1}}};
  localparam logic signed [B-1:0] BIG_MIN = {1'b1, {(B-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, ACCUM, LEAK, FIRE} state_t;

  state_t              state_q, state_d;
  logic signed [M-1:0] acc_q, acc_d;
  logic [7:0]          cnt_q, cnt_d;
  logic                err_q, err_d;
  logic signed [M-1:0] memHold_q, memHold_d;
  logic signed [B-1:0] bigHold_q, bigHold_d;

  logic signed [M:0]   accWide;
  logic signed [M-1:0] accSum;
  logic signed [M-1:0] accLeak;
  logic signed [B:0]   bigWide;
  logic signed [B-1:0] bigSum;
  logic                inFire;
  logic                fireNow;
  logic                protoErr;

  // One guard bit is enough to detect overflow; clamp instead of wrapping.
  assign accWide = {acc_q[M-1], acc_q} + {{(M+1-W){spike_weight_i[W-1]}}, spike_weight_i};
  assign accSum  = (accWide[M] != accWide[M-1]) ? (accWide[M] ? MEM_MIN : MEM_MAX)
                                                : accWide[M-1:0];
  assign accLeak = acc_q - (acc_q >>> LEAK_SHIFT);

  assign bigWide = {{(B+1-M){acc_q[M-1]}}, acc_q} + {big_membrane_i[B-1], big_membrane_i};
  assign bigSum  = (bigWide[B] != bigWide[B-1]) ? (bigWide[B] ? BIG_MIN : BIG_MAX)
                                                : bigWide[B-1:0];

  assign inFire   = (state_q == FIRE);
  assign fireNow  = inFire && (acc_q >= threshold_i);
  assign protoErr = (ts_start_i && (state_q != IDLE)) ||
                    ((spike_valid_i || ts_end_i) && (state_q != ACCUM));

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    err_d     = err_q | protoErr;
    memHold_d = memHold_q;
    bigHold_d = bigHold_q;
    case (state_q)
      IDLE: begin
        if (ts_start_i) begin
          acc_d   = membrane_i;
          cnt_d   = 8'd0;
          state_d = ACCUM;
        end
      end
      ACCUM: begin
        if (spike_valid_i) begin
          acc_d = accSum;
          cnt_d = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
        end
        if (ts_end_i) state_d = LEAK;
      end
      LEAK: begin
        acc_d   = accLeak;
        state_d = FIRE;
      end
      FIRE: begin
        // A firing neuron resets itself, so only a non-firing result is written back.
        if (!fireNow) memHold_d = acc_q;
        bigHold_d = bigSum;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      acc_q     <= '0;
      cnt_q     <= '0;
      err_q     <= 1'b0;
      memHold_q <= '0;
      bigHold_q <= '0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      err_q     <= err_d;
      memHold_q <= memHold_d;
      bigHold_q <= bigHold_d;
    end
  end

  assign membrane_update_valid_o     = inFire && !fireNow;
  assign membrane_update_o           = membrane_update_valid_o ? acc_q : memHold_q;
  assign big_membrane_update_valid_o = inFire;
  assign big_membrane_update_o       = inFire ? bigSum : bigHold_q;
  assign post_spiking_now_o          = fireNow;
  assign done_o                      = inFire;
  assign busy_o                      = (state_q != IDLE);
  assign spike_cnt_o                 = cnt_q;
  assign err_o                       = err_q;

endmodule

// File: tb/tb_neuron_layer3_integrator.sv
// Bench for neuron_layer3_integrator: a per-timestep arithmetic model sets the
// expected outputs each cycle and a negedge process compares them against the DUT.
module tb_neuron_layer3_integrator;

  logic               clk = 1'b0;
  logic               reset_n = 1'b0;
  logic               ts_start_i = 1'b0;
  logic               spike_valid_i = 1'b0;
  logic signed [7:0]  spike_weight_i = '0;
  logic               ts_end_i = 1'b0;
  logic signed [15:0] threshold_i = '0;
  logic signed [15:0] membrane_i = '0;
  logic signed [15:0] big_membrane_i = '0;
  logic signed [15:0] membrane_update_o;
  logic               membrane_update_valid_o;
  logic signed [15:0] big_membrane_update_o;
  logic               big_membrane_update_valid_o;
  logic               post_spiking_now_o;
  logic               busy_o;
  logic               done_o;
  logic [7:0]         spike_cnt_o;
  logic               err_o;

  int testsRun = 0;
  int testsFailed = 0;
  bit checkEn = 1'b0;

  int expBusy, expDone, expFire, expMemValid, expMem, expBigValid, expBig, expCnt;
  int expErr = 0;
  int memHold = 0;
  int bigHold = 0;
  int wq[$];

  neuron_layer3_integrator #(
    .BIT_WIDTH_MEMBRANE(16),
    .BIT_WIDTH_BIG_MEMBRANE(16),
    .BIT_WIDTH_WEIGHT(8),
    .LEAK_SHIFT(3)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .ts_start_i(ts_start_i),
    .spike_valid_i(spike_valid_i),
    .spike_weight_i(spike_weight_i),
    .ts_end_i(ts_end_i),
    .threshold_i(threshold_i),
    .membrane_i(membrane_i),
    .big_membrane_i(big_membrane_i),
    .membrane_update_o(membrane_update_o),
    .membrane_update_valid_o(membrane_update_valid_o),
    .big_membrane_update_o(big_membrane_update_o),
    .big_membrane_update_valid_o(big_membrane_update_valid_o),
    .post_spiking_now_o(post_spiking_now_o),
    .busy_o(busy_o),
    .done_o(done_o),
    .spike_cnt_o(spike_cnt_o),
    .err_o(err_o)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input int actual, input int expected);
    testsRun++;
    if (actual != expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  always @(negedge clk) begin
    if (checkEn) begin
      checkOutput("busy", int'(busy_o), expBusy);
      checkOutput("done", int'(done_o), expDone);
      checkOutput("post_spike", int'(post_spiking_now_o), expFire);
      checkOutput("mem_valid", int'(membrane_update_valid_o), expMemValid);
      checkOutput("mem_update", int'(membrane_update_o), expMem);
      checkOutput("big_valid", int'(big_membrane_update_valid_o), expBigValid);
      checkOutput("big_update", int'(big_membrane_update_o), expBig);
      checkOutput("spike_cnt", int'(spike_cnt_o), expCnt);
      checkOutput("err", int'(err_o), expErr);
    end
  end

  function automatic int sat16(input int v);
    if (v > 32767) return 32767;
    if (v < -32768) return -32768;
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic setExp(input int busy, input int done, input int fire, input int mv,
                        input int bv, input int cnt);
    expBusy = busy; expDone = done; expFire = fire; expMemValid = mv;
    expBigValid = bv; expCnt = cnt; expMem = memHold; expBig = bigHold;
  endtask

  // One full timestep with the spike weights in wq; the lit* values are
  // hand-computed and pin both the model and the DUT at the FIRE cycle.
  task automatic applyStimulus(input int mem, input int big, input int thr, input bit endSeparate,
                               input int litLeak, input int litBig, input int litCnt,
                               input int litFire);
    int  acc, cnt, leak, bigv;
    bit  fire;
    membrane_i = 16'(mem); big_membrane_i = 16'(big); threshold_i = 16'(thr);
    ts_start_i = 1'b1;
    tick();
    ts_start_i = 1'b0;
    acc = mem; cnt = 0;
    setExp(1, 0, 0, 0, 0, 0);
    foreach (wq[i]) begin
      spike_valid_i  = 1'b1;
      spike_weight_i = wq[i][7:0];
      ts_end_i       = !endSeparate && (i == wq.size() - 1);
      tick();
      spike_valid_i = 1'b0; ts_end_i = 1'b0;
      acc = sat16(acc + wq[i]);
      cnt = (cnt < 255) ? cnt + 1 : 255;
      setExp(1, 0, 0, 0, 0, cnt);
    end
    if (endSeparate || wq.size() == 0) begin
      ts_end_i = 1'b1;
      tick();
      ts_end_i = 1'b0;
      setExp(1, 0, 0, 0, 0, cnt);
    end
    tick();
    leak = acc - (acc >>> 3);
    fire = (leak >= thr);
    bigv = sat16(big + leak);
    if (!fire) memHold = leak;
    bigHold = bigv;
    setExp(1, 1, int'(fire), int'(!fire), 1, cnt);
    checkOutput("model_leak", leak, litLeak);
    checkOutput("model_cnt", cnt, litCnt);
    checkOutput("lit_fire", int'(post_spiking_now_o), litFire);
    checkOutput("lit_big", int'(big_membrane_update_o), litBig);
    if (litFire == 0) checkOutput("lit_mem", int'(membrane_update_o), litLeak);
    tick();
    setExp(0, 0, 0, 0, 0, cnt);
    tick();
  endtask

  initial begin
    setExp(0, 0, 0, 0, 0, 0);
    checkEn = 1'b1;
    tick();
    tick();
    reset_n = 1'b1;
    tick();

    wq = '{10, 20, 30};
    applyStimulus(100, 0, 1000, 1'b1, 140, 140, 3, 0);
    wq = '{127, 127};
    applyStimulus(900, 0, 1000, 1'b0, 1010, 1010, 2, 1);
    wq = '{127};
    applyStimulus(32760, 10000, 32767, 1'b0, 28672, 32767, 1, 0);
    wq = '{};
    applyStimulus(-100, 0, 1000, 1'b1, -87, -87, 0, 0);
    wq = '{-128, -128};
    applyStimulus(-32700, -10000, 0, 1'b1, -28672, -32768, 2, 0);
    wq = '{10, 20, 30};
    applyStimulus(100, 0, 140, 1'b1, 140, 140, 3, 1);
    wq = '{};
    for (int i = 0; i < 300; i++) wq.push_back(1);
    applyStimulus(0, 0, 1000, 1'b1, 263, 263, 255, 0);

    // Abort a timestep mid-accumulation; no FIRE may follow.
    membrane_i = 16'sd500; ts_start_i = 1'b1;
    tick();
    ts_start_i = 1'b0;
    setExp(1, 0, 0, 0, 0, 0);
    spike_valid_i = 1'b1; spike_weight_i = 8'sd5;
    tick();
    spike_valid_i = 1'b0;
    setExp(1, 0, 0, 0, 0, 1);
    reset_n = 1'b0;
    memHold = 0; bigHold = 0;
    setExp(0, 0, 0, 0, 0, 0);
    tick();
    reset_n = 1'b1;
    tick();
    tick();
    tick();

    // A stray spike while idle is a protocol error and sticks until reset.
    spike_valid_i = 1'b1; spike_weight_i = 8'sd50;
    tick();
    spike_valid_i = 1'b0;
    expErr = 1;
    setExp(0, 0, 0, 0, 0, 0);
    tick();
    wq = '{10, 20, 30};
    applyStimulus(100, 0, 1000, 1'b1, 140, 140, 3, 0);

    checkEn = 1'b0;
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
